subtractor_32bit: RTL and testbench

Registered 32-bit binary subtractor with borrow-in/borrow-out for the performance-oriented ALU datapath. Computes subtractor_in0 - subtractor_in1 - borrow_in using a two-level borrow-lookahead structure (4-bit groups, 8 groups). Results and status flags are registered with one cycle of latency. Sits beside the adder and logic units, feeding the ALU result mux.

---
 rtl/subtractor_32bit.sv | 142 ++++++++++++++
 tb/tb_subtractor_32bit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/subtractor_32bit.sv
// Registered 32-bit subtractor with borrow-in/borrow-out and status flags.
// Computes subtractor_in0 - subtractor_in1 - borrow_in with a two-level borrow
// lookahead: 4-bit groups, then a group-level lookahead, so no borrow ripples
// between groups. All outputs are registered, so results appear one cycle
// after the operands.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears every output
//   in_valid       operands valid this cycle
//   subtractor_in0 minuend
//   subtractor_in1 subtrahend
//   borrow_in      borrow into bit 0 (subtracts an extra 1)
//   out_valid      registered results valid
//   subtractor_out difference mod 2^32
//   borrow_out     borrow out of bit 31 (unsigned in0 < in1 + borrow_in)
//   zero_flag      difference == 0
//   negative_flag  difference[31]
//   overflow_flag  signed two's-complement overflow
module subtractor_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] subtractor_in0,
  input  logic [WIDTH-1:0] subtractor_in1,
  input  logic             borrow_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] subtractor_out,
  output logic             borrow_out,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag
);

  localparam int unsigned NGroups = WIDTH / GROUP;

  logic [WIDTH-1:0]   bit_g;    // bit generates a borrow: a=0, b=1
  logic [WIDTH-1:0]   bit_p;    // bit passes an incoming borrow: a==b
  logic [WIDTH-1:0]   bit_bin;  // borrow into each bit
  logic [NGroups-1:0] grp_g;
  logic [NGroups-1:0] grp_p;
  logic [NGroups:0]   grp_bin;  // borrow into each group; [NGroups] is the final borrow out

  logic [WIDTH-1:0] diff_d, diff_q;
  logic             borrow_d, borrow_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // First level: per-bit and per-group generate/propagate.
  always_comb begin
    bit_g = ~subtractor_in0 & subtractor_in1;
    bit_p = ~(subtractor_in0 ^ subtractor_in1);
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < int'(NGroups); k++) begin
      logic gg;
      logic gp;
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < int'(GROUP); i++) begin
        gg = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & gg);
        gp = gp & bit_p[k*GROUP+i];
      end
      grp_g[k] = gg;
      grp_p[k] = gp;
    end
  end

  // Second level: each group borrow-in is a flat sum of products over the
  // lower groups' G/P and borrow_in, so no group waits on another's output.
  always_comb begin
    grp_bin = '0;
    for (int k = 0; k <= int'(NGroups); k++) begin
      logic acc;
      logic chain;
      acc   = 1'b0;
      chain = 1'b1;
      // Walk downward from group k-1, accumulating the propagate product.
      for (int j = k - 1; j >= 0; j--) begin
        acc   = acc | (chain & grp_g[j]);
        chain = chain & grp_p[j];
      end
      grp_bin[k] = acc | (chain & borrow_in);
    end
  end

  // Bit-level borrows inside each group, seeded by the group borrow-in.
  always_comb begin
    bit_bin = '0;
    for (int k = 0; k < int'(NGroups); k++) begin
      logic b;
      b = grp_bin[k];
      for (int i = 0; i < int'(GROUP); i++) begin
        bit_bin[k*GROUP+i] = b;
        b = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & b);
      end
    end
  end

  always_comb begin
    diff_d   = subtractor_in0 ^ subtractor_in1 ^ bit_bin;
    borrow_d = grp_bin[NGroups];
    zero_d   = (diff_d == '0);
    neg_d    = diff_d[WIDTH-1];
    ovf_d    = (subtractor_in0[WIDTH-1] != subtractor_in1[WIDTH-1]) &&
               (diff_d[WIDTH-1] != subtractor_in0[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Result registers hold their last value while idle.
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
        zero_q   <= zero_d;
        neg_q    <= neg_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid      = valid_q;
  assign subtractor_out = diff_q;
  assign borrow_out     = borrow_q;
  assign zero_flag      = zero_q;
  assign negative_flag  = neg_q;
  assign overflow_flag  = ovf_q;

endmodule

// File: tb/tb_subtractor_32bit.sv
// Directed-vector bench for subtractor_32bit with hand-computed expectations.
module tb_subtractor_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        bin;
  logic        out_valid;
  logic [31:0] dout;
  logic        bout;
  logic        zf;
  logic        nf;
  logic        of;

  int checks = 0;
  int errors = 0;

  subtractor_32bit #(
    .WIDTH(32),
    .GROUP(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .subtractor_in0(in0),
    .subtractor_in1(in1),
    .borrow_in     (bin),
    .out_valid     (out_valid),
    .subtractor_out(dout),
    .borrow_out    (bout),
    .zero_flag     (zf),
    .negative_flag (nf),
    .overflow_flag (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                         input logic b, input logic z, input logic n, input logic o);
    chk({tag, ".valid"},  {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".diff"},   dout,               d);
    chk({tag, ".borrow"}, {31'd0, bout},      {31'd0, b});
    chk({tag, ".zero"},   {31'd0, zf},        {31'd0, z});
    chk({tag, ".neg"},    {31'd0, nf},        {31'd0, n});
    chk({tag, ".ovf"},    {31'd0, of},        {31'd0, o});
  endtask

  // Drive an operation on the falling edge, check it just after the next rising edge.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic bi, input logic [31:0] d, input logic bo,
                    input logic z, input logic n, input logic o);
    @(negedge clk);
    in_valid = 1'b1;
    in0      = a;
    in1      = b;
    bin      = bi;
    @(posedge clk);
    #1;
    chk_all(tag, 1'b1, d, bo, z, n, o);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in0      = '0;
    in1      = '0;
    bin      = 1'b0;
    #2;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release with in_valid low: nothing should appear.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle_after_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    //   tag          in0           in1           bin   diff          bo    z     n     o
    op("basic",     32'd10,       32'd5,        1'b0, 32'd5,        1'b0, 1'b0, 1'b0, 1'b0);
    op("eq15",      32'd15,       32'd15,       1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    op("eqmax",     32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
    op("under",     32'd7,        32'd9,        1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0);
    op("bin20",     32'd20,       32'd5,        1'b1, 32'd14,       1'b0, 1'b0, 1'b0, 1'b0);
    op("bin_min",   32'h80000000, 32'h80000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op("ovf_min",   32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op("chain0",    32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op("mixed",     32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h03254769, 1'b0, 1'b0, 1'b0, 1'b0);
    op("zero_mmin", 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);
    op("max_m1",    32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);
    op("ones_bin",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op("grp_chain", 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle: out_valid drops, results hold.
    @(negedge clk);
    in_valid = 1'b0;
    in0      = 32'hDEADBEEF;
    in1      = 32'h1;
    @(posedge clk);
    #1;
    chk_all("hold", 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three back-to-back operations.
    op("b2b_0", 32'd100,      32'd1,        1'b0, 32'd99,       1'b0, 1'b0, 1'b0, 1'b0);
    op("b2b_1", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    op("b2b_2", 32'h40000000, 32'hC0000000, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-stream with another operation in flight.
    @(negedge clk);
    in0 = 32'd50;
    in1 = 32'd60;
    bin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    op("post_reset_op", 32'd3, 32'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
